// File: rtl/dcache_pkg.sv
// ============================================================================
// Module  : dcache_pkg
// Shared types, field widths and address-field helpers for the data cache.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dcache_pkg;

    localparam int ADDR_W  = 8;
    localparam int TAG_W   = 3;
    localparam int IDX_W   = 3;
    localparam int OFF_W   = 2;
    localparam int BLOCK_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } dcache_state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_line_store.sv
// ============================================================================
// Module  : dcache_line_store
// Valid/dirty/tag/data arrays with one read port, byte-write and block-fill.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int LINE_W     = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [IDX_W-1:0]  rd_index,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [OFF_W-1:0]  wr_offset,
    input  logic [7:0]        wr_byte,
    input  logic              fill_en,
    input  logic [IDX_W-1:0]  fill_index,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_data
);

    logic [NUM_BLOCKS-1:0] r_valid;
    logic [NUM_BLOCKS-1:0] r_dirty;
    logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
    logic [LINE_W-1:0]     r_data [NUM_BLOCKS];

    // Only the status bits are cleared; stale tags are harmless once valid drops.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (fill_en) begin
            r_valid[fill_index] <= 1'b1;
            r_dirty[fill_index] <= 1'b0;
        end else if (wr_en) begin
            r_dirty[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_en) begin
            r_tag[fill_index]  <= fill_tag;
            r_data[fill_index] <= fill_data;
        end else if (wr_en) begin
            r_data[wr_index][{wr_offset, 3'b000} +: 8] <= wr_byte;
        end
    end

    assign rd_valid = r_valid[rd_index];
    assign rd_dirty = r_dirty[rd_index];
    assign rd_tag   = r_tag[rd_index];
    assign rd_data  = r_data[rd_index];

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
// Module  : dcache_ctrl
// Direct-mapped write-back, write-allocate data cache controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_BLOCKS  = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     READMEM,
    input  logic                     WRITEMEM,
    input  logic [7:0]               ADDRESS,
    input  logic [7:0]               WRITEDATA,
    output logic [7:0]               READDATA,
    output logic                     BUSYWAIT,
    output logic                     MEM_READ,
    output logic                     MEM_WRITE,
    output logic [5:0]               MEM_ADDRESS,
    output logic [BLOCK_BYTES*8-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_BYTES*8-1:0] MEM_READDATA,
    input  logic                     MEM_BUSYWAIT
);

    localparam int c_LINE_W = BLOCK_BYTES * 8;

    dcache_state_e r_state;
    dcache_state_e w_state_next;
    logic          r_done;
    logic          w_done_next;

    logic                w_req;
    logic [TAG_W-1:0]    w_tag;
    logic [IDX_W-1:0]    w_index;
    logic [OFF_W-1:0]    w_offset;
    logic                w_hit;
    logic                w_line_valid;
    logic                w_line_dirty;
    logic [TAG_W-1:0]    w_line_tag;
    logic [c_LINE_W-1:0] w_line_data;
    logic                w_wr_en;
    logic                w_fill_en;

    assign w_req    = READMEM | WRITEMEM;
    assign w_tag    = addr_tag(ADDRESS);
    assign w_index  = addr_index(ADDRESS);
    assign w_offset = addr_offset(ADDRESS);
    assign w_hit    = w_line_valid & (w_line_tag == w_tag);

    dcache_line_store #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .LINE_W     (c_LINE_W)
    ) u_line_store (
        .CLK        (CLK),
        .RESET      (RESET),
        .rd_index   (w_index),
        .rd_valid   (w_line_valid),
        .rd_dirty   (w_line_dirty),
        .rd_tag     (w_line_tag),
        .rd_data    (w_line_data),
        .wr_en      (w_wr_en),
        .wr_index   (w_index),
        .wr_offset  (w_offset),
        .wr_byte    (WRITEDATA),
        .fill_en    (w_fill_en),
        .fill_index (w_index),
        .fill_tag   (w_tag),
        .fill_data  (MEM_READDATA)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    // While done is high the access just completed; nothing is serviced that cycle.
    always_comb begin
        w_state_next  = r_state;
        w_done_next   = 1'b0;
        w_wr_en       = 1'b0;
        w_fill_en     = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        case (r_state)
            IDLE: begin
                if (w_req && !r_done) begin
                    if (w_hit) begin
                        w_done_next = 1'b1;
                        w_wr_en     = WRITEMEM;
                    end else if (w_line_dirty) begin
                        w_state_next = WRITEBACK;
                    end else begin
                        w_state_next = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {w_line_tag, w_index};
                MEM_WRITEDATA = w_line_data;
                if (!MEM_BUSYWAIT) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {w_tag, w_index};
                if (!MEM_BUSYWAIT) begin
                    w_fill_en    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign READDATA = w_line_data[{w_offset, 3'b000} +: 8];
    assign BUSYWAIT = w_req & ~r_done;

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ============================================================================
// Module  : tb_dcache_ctrl
// Directed self-checking bench for dcache_ctrl with a fixed-latency memory.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dcache_ctrl;

    localparam int MEM_LAT = 3;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        READMEM = 1'b0;
    logic        WRITEMEM = 1'b0;
    logic [7:0]  ADDRESS = 8'h00;
    logic [7:0]  WRITEDATA = 8'h00;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    logic [31:0] mem [64] = '{9: 32'hDDCCBBAA, 17: 32'h11223344,
                              33: 32'hA1B2C3D4, default: 32'h0};
    int          mem_cnt = 0;

    int          checks = 0;
    int          failures = 0;
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    logic [5:0]  last_rd_addr = 6'h0;
    logic [5:0]  last_wr_addr = 6'h0;
    logic [31:0] last_wr_data = 32'h0;

    dcache_ctrl dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READMEM       (READMEM),
        .WRITEMEM      (WRITEMEM),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory: busy for MEM_LAT cycles, then completes on the next edge.
    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt != MEM_LAT);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (MEM_READ || MEM_WRITE) begin
            if (mem_cnt == MEM_LAT) begin
                mem_cnt <= 0;
                if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    always @(negedge CLK) begin
        if (MEM_READ) begin
            rd_cycles    = rd_cycles + 1;
            last_rd_addr = MEM_ADDRESS;
        end
        if (MEM_WRITE) begin
            wr_cycles    = wr_cycles + 1;
            last_wr_addr = MEM_ADDRESS;
            last_wr_data = MEM_WRITEDATA;
        end
    end

    task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [7:0] wdata, output int busy, output logic [7:0] rdata);
        logic finished;
        busy     = 0;
        rdata    = 8'h00;
        finished = 1'b0;
        @(posedge CLK); #1;
        READMEM = rd; WRITEMEM = wr; ADDRESS = addr; WRITEDATA = wdata;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!BUSYWAIT) begin
                rdata    = READDATA;
                finished = 1'b1;
                break;
            end
            busy++;
        end
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL access_timeout addr=%h: BUSYWAIT stuck high after %0d cycles, required low", addr, busy);
        end
        @(posedge CLK); #1;
        READMEM = 1'b0; WRITEMEM = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0; READMEM = 1'b0; WRITEMEM = 1'b0;
        #2;
        checks++; if (BUSYWAIT !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSYWAIT); end
        checks++; if (MEM_READ !== 1'b0)   begin failures++; $display("FAIL reset_mem_read got=%b exp=0", MEM_READ); end
        checks++; if (MEM_WRITE !== 1'b0)  begin failures++; $display("FAIL reset_mem_write got=%b exp=0", MEM_WRITE); end
        checks++; if (MEM_ADDRESS !== 6'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=00", MEM_ADDRESS); end
        checks++; if (MEM_WRITEDATA !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", MEM_WRITEDATA); end
        READMEM = 1'b1; #1;
        checks++; if (BUSYWAIT !== 1'b1)   begin failures++; $display("FAIL reset_busy_req got=%b exp=1", BUSYWAIT); end
        READMEM = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        RESET = 1'b1;
    endtask

    task automatic test_cold_read();
        int busy, r0, w0;
        logic [7:0] d;
        r0 = rd_cycles; w0 = wr_cycles;
        cpu_access(1'b1, 1'b0, 8'h25, 8'h00, busy, d);
        checks++; if (d !== 8'hBB)          begin failures++; $display("FAIL cold_data got=%h exp=bb", d); end
        checks++; if (busy !== 6)           begin failures++; $display("FAIL cold_busy got=%0d exp=6", busy); end
        checks++; if (rd_cycles - r0 !== 4) begin failures++; $display("FAIL cold_fetch_cycles got=%0d exp=4", rd_cycles - r0); end
        checks++; if (last_rd_addr !== 6'h09) begin failures++; $display("FAIL cold_fetch_addr got=%h exp=09", last_rd_addr); end
        checks++; if (wr_cycles !== w0)     begin failures++; $display("FAIL cold_no_wb got=%0d exp=%0d", wr_cycles, w0); end
        r0 = rd_cycles;
        cpu_access(1'b1, 1'b0, 8'h24, 8'h00, busy, d);
        checks++; if (d !== 8'hAA)          begin failures++; $display("FAIL cold_rehit_data got=%h exp=aa", d); end
        checks++; if (busy !== 1 || rd_cycles !== r0) begin failures++; $display("FAIL cold_rehit busy=%0d reads=%0d exp busy=1 reads=%0d", busy, rd_cycles, r0); end
    endtask

    task automatic test_write_hit();
        int busy, r0, w0;
        logic [7:0] d;
        r0 = rd_cycles; w0 = wr_cycles;
        cpu_access(1'b0, 1'b1, 8'h25, 8'h7E, busy, d);
        checks++; if (busy !== 1)           begin failures++; $display("FAIL wr_hit_busy got=%0d exp=1", busy); end
        cpu_access(1'b1, 1'b0, 8'h25, 8'h00, busy, d);
        checks++; if (d !== 8'h7E)          begin failures++; $display("FAIL wr_hit_readback got=%h exp=7e", d); end
        checks++; if (busy !== 1)           begin failures++; $display("FAIL wr_hit_read_busy got=%0d exp=1", busy); end
        checks++; if (rd_cycles !== r0 || wr_cycles !== w0) begin failures++; $display("FAIL wr_hit_traffic reads=%0d writes=%0d exp %0d %0d", rd_cycles, wr_cycles, r0, w0); end
    endtask

    task automatic test_dirty_miss();
        int busy, r0, w0;
        logic [7:0] d;
        r0 = rd_cycles; w0 = wr_cycles;
        cpu_access(1'b1, 1'b0, 8'h45, 8'h00, busy, d);
        checks++; if (wr_cycles - w0 !== 4) begin failures++; $display("FAIL dirty_wb_cycles got=%0d exp=4", wr_cycles - w0); end
        checks++; if (last_wr_addr !== 6'h09) begin failures++; $display("FAIL dirty_wb_addr got=%h exp=09", last_wr_addr); end
        checks++; if (last_wr_data !== 32'hDDCC7EAA) begin failures++; $display("FAIL dirty_wb_data got=%h exp=ddcc7eaa", last_wr_data); end
        checks++; if (mem[9] !== 32'hDDCC7EAA) begin failures++; $display("FAIL dirty_mem_update got=%h exp=ddcc7eaa", mem[9]); end
        checks++; if (rd_cycles - r0 !== 4) begin failures++; $display("FAIL dirty_fetch_cycles got=%0d exp=4", rd_cycles - r0); end
        checks++; if (last_rd_addr !== 6'h11) begin failures++; $display("FAIL dirty_fetch_addr got=%h exp=11", last_rd_addr); end
        checks++; if (busy !== 10)          begin failures++; $display("FAIL dirty_busy got=%0d exp=10", busy); end
        checks++; if (d !== 8'h33)          begin failures++; $display("FAIL dirty_data got=%h exp=33", d); end
    endtask

    task automatic test_both_high();
        int busy, r0, w0;
        logic [7:0] d;
        w0 = wr_cycles;
        cpu_access(1'b1, 1'b0, 8'h25, 8'h00, busy, d);
        checks++; if (d !== 8'h7E || busy !== 6 || wr_cycles !== w0) begin failures++; $display("FAIL both_refill data=%h busy=%0d writes=%0d exp 7e 6 %0d", d, busy, wr_cycles, w0); end
        r0 = rd_cycles;
        cpu_access(1'b1, 1'b1, 8'h25, 8'h5A, busy, d);
        checks++; if (busy !== 1 || rd_cycles !== r0 || wr_cycles !== w0) begin failures++; $display("FAIL both_hit busy=%0d reads=%0d writes=%0d exp 1 %0d %0d", busy, rd_cycles, wr_cycles, r0, w0); end
        cpu_access(1'b1, 1'b0, 8'h25, 8'h00, busy, d);
        checks++; if (d !== 8'h5A)          begin failures++; $display("FAIL both_readback got=%h exp=5a", d); end
        cpu_access(1'b1, 1'b0, 8'h45, 8'h00, busy, d);
        checks++; if (wr_cycles - w0 !== 4) begin failures++; $display("FAIL both_dirty_wb got=%0d exp=4", wr_cycles - w0); end
        checks++; if (last_wr_data !== 32'hDDCC5AAA) begin failures++; $display("FAIL both_wb_data got=%h exp=ddcc5aaa", last_wr_data); end
        checks++; if (d !== 8'h33)          begin failures++; $display("FAIL both_after_data got=%h exp=33", d); end
    endtask

    task automatic test_reset_mid_fetch();
        int busy, r0, w0;
        logic [7:0] d;
        logic seen;
        seen = 1'b0;
        @(posedge CLK); #1;
        READMEM = 1'b1; ADDRESS = 8'h85;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (MEM_READ) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin failures++; $display("FAIL rst_fetch_start MEM_READ=0 exp=1"); end
        #2 RESET = 1'b0;
        #1;
        checks++; if (MEM_READ !== 1'b0)    begin failures++; $display("FAIL rst_mem_read got=%b exp=0", MEM_READ); end
        checks++; if (MEM_ADDRESS !== 6'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=00", MEM_ADDRESS); end
        checks++; if (BUSYWAIT !== 1'b1)    begin failures++; $display("FAIL rst_busy got=%b exp=1", BUSYWAIT); end
        READMEM = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        RESET = 1'b1;
        r0 = rd_cycles; w0 = wr_cycles;
        cpu_access(1'b1, 1'b0, 8'h45, 8'h00, busy, d);
        checks++; if (rd_cycles - r0 !== 4 || last_rd_addr !== 6'h11) begin failures++; $display("FAIL rst_refetch reads=%0d addr=%h exp 4 11", rd_cycles - r0, last_rd_addr); end
        checks++; if (wr_cycles !== w0 || busy !== 6) begin failures++; $display("FAIL rst_refetch_clean writes=%0d busy=%0d exp %0d 6", wr_cycles, busy, w0); end
        checks++; if (d !== 8'h33)          begin failures++; $display("FAIL rst_refetch_data got=%h exp=33", d); end
    endtask

    task automatic test_back_to_back();
        int r0, w0;
        logic [3:0] pat;
        logic [7:0] d;
        r0 = rd_cycles; w0 = wr_cycles; d = 8'h00;
        @(posedge CLK); #1;
        READMEM = 1'b1; ADDRESS = 8'h45;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            pat[3-i] = BUSYWAIT;
            if (i == 1) d = READDATA;
        end
        @(posedge CLK); #1;
        READMEM = 1'b0;
        checks++; if (pat !== 4'b1010)      begin failures++; $display("FAIL b2b_busy_pattern got=%b exp=1010", pat); end
        checks++; if (d !== 8'h33)          begin failures++; $display("FAIL b2b_data got=%h exp=33", d); end
        checks++; if (rd_cycles !== r0 || wr_cycles !== w0) begin failures++; $display("FAIL b2b_traffic reads=%0d writes=%0d exp %0d %0d", rd_cycles, wr_cycles, r0, w0); end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_write_hit();
        test_dirty_miss();
        test_both_high();
        test_reset_mid_fetch();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
